serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 154 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one structural full adder (two half adders + OR) is
// stepped over WIDTH cycles, LSB first, with a start/busy/done handshake.

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module or_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a | i_b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s1;
  logic             w_c1;
  logic             w_s;
  logic             w_c2;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_opa_next;
  logic [WIDTH-1:0] w_opb_next;
  logic             w_accept;
  logic             w_last;

  // 1-bit datapath: full adder assembled from the gate library
  half_adder u_ha1 (
    .i_a (r_opa[0]),
    .i_b (r_opb[0]),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  half_adder u_ha2 (
    .i_a (w_s1),
    .i_b (r_carry),
    .o_s (w_s),
    .o_c (w_c2)
  );

  or_gate u_or (
    .i_a (w_c1),
    .i_b (w_c2),
    .o_y (w_carry_next)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts the first
  // computed bit has arrived at the LSB; operands shift toward bit 0.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign w_acc_next[gi] = r_acc[gi+1];
      assign w_opa_next[gi] = r_opa[gi+1];
      assign w_opb_next[gi] = r_opb[gi+1];
    end
  endgenerate

  assign w_acc_next[WIDTH-1] = w_s;
  assign w_opa_next[WIDTH-1] = 1'b0;
  assign w_opb_next[WIDTH-1] = 1'b0;

  // A request is only taken when not mid-operation; DONE accepts so that
  // back-to-back adds need no idle cycle in between.
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state <= ST_RUN;
            r_opa   <= a;
            r_opb   <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          r_carry <= w_carry_next;
          r_acc   <= w_acc_next;
          r_opa   <= w_opa_next;
          r_opb   <= w_opb_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          // Result registers change only here so they stay stable during runs
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_carry_next;
            r_state <= ST_DONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.

module tb_serial_adder_ctrl;

  localparam int W   = 8;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(posedge clk) begin
    #1;
    if (busy === 1'b1 && done === 1'b1)
      check("busy_done_overlap", 1, 0);
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("c_out", 32'(c_out), 32'(e.cout));
        check("done_cycle", cyc, e.cyc);
        $display("done: sum=0x%02h c_out=%0d at cycle %0d", sum, c_out, cyc);
      end
    end
  end

  function automatic exp_t mk_exp(input logic [W-1:0] s, input logic co, input int c);
    exp_t e;
    e.sum  = s;
    e.cout = co;
    e.cyc  = c;
    return e;
  endfunction

  // Single start pulse issued at the current negedge; busy is checked over
  // the following WIDTH cycles.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] es, input logic ec);
    int c0;
    c0    = cyc;
    a     = va;
    b     = vb;
    start = 1'b1;
    sb_q.push_back(mk_exp(es, ec, c0 + LAT));
    $display("issue: a=0x%02h b=0x%02h expect sum=0x%02h c_out=%0d", va, vb, es, ec);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      check("busy_run", 32'(busy), 1);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int c0;
    n_checks = 0;
    n_fail   = 0;

    // Reset held two cycles with start asserted
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h01;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_sum", 32'(sum), 0);
      check("rst_cout", 32'(c_out), 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(busy), 0);

    // Directed vectors with hand-computed results
    vecs.push_back('{8'hFF, 8'h01, 8'h00, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 8'hFF, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 8'h80, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 8'hFE, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 8'h46, 1'b0});
    vecs.push_back('{8'hC8, 8'h64, 8'h2C, 1'b1});
    vecs.push_back('{8'h55, 8'hAA, 8'hFF, 1'b0});
    vecs.push_back('{8'h01, 8'hFF, 8'h00, 1'b1});
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
      wait_drain(20);
      check("sum_hold_idle", 32'(sum), 32'(vecs[i].s));
    end

    // Random operands against the arithmetic reference
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W:0]   rs;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rs = {1'b0, ra} + {1'b0, rb};
      issue(ra, rb, rs[W-1:0], rs[W]);
      wait_drain(20);
    end

    // Start re-pulsed mid-run must be ignored
    c0    = cyc;
    a     = 8'h01;
    b     = 8'h01;
    start = 1'b1;
    sb_q.push_back(mk_exp(8'h02, 1'b0, c0 + LAT));
    $display("issue: a=0x01 b=0x01 with ignored re-pulse at cycle 3");
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_drain(20);
    repeat (12) @(negedge clk);
    check("ignored_no_run", 32'(busy), 0);

    // Back-to-back: start held through two DONE cycles
    c0    = cyc;
    a     = 8'h0F;
    b     = 8'h01;
    start = 1'b1;
    for (int k = 1; k <= 3; k++)
      sb_q.push_back(mk_exp(8'h10, 1'b0, c0 + k * LAT));
    $display("issue: a=0x0F b=0x01 start held for three results");
    while (cyc < c0 + 20) @(negedge clk);
    start = 1'b0;
    wait_drain(40);
    repeat (3) @(negedge clk);
    check("b2b_idle", 32'(busy), 0);

    // Reset during RUN aborts with no done
    c0    = cyc;
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    $display("issue: a=0xFF b=0xFF aborted by reset at cycle 4");
    @(negedge clk); start = 1'b0;
    while (cyc < c0 + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_sum", 32'(sum), 0);
    check("abort_cout", 32'(c_out), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_restart", 32'(busy), 0);
    issue(8'hFF, 8'hFF, 8'hFE, 1'b1);
    wait_drain(20);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
